// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the transmit and receive paths.
//   rx_state_t   : receiver frame-phase states
//   DATA_BITS    : payload bits per frame
//   FRAME_BITS   : start + data + parity + stop
//   PARITY_EVEN / PARITY_ODD : parity-mode encodings for the PARITY_ODD parameter
//   majority3()  : 2-of-3 vote used by the mid-bit sampler
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

  // Two-of-three majority, used to reject a single corrupted oversample.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sipo.sv
// -----------------------------------------------------------------------------
// uart_rx_sipo
// Serial-in / parallel-out register for the UART receiver. Each received
// bit is written straight into its slot instead of being shifted, so the
// byte comes out already in line order (data[0] = first bit received).
// Ports:
//   clk      : receive clock
//   rst_n    : asynchronous active-low reset, clears the register
//   wr_en    : write the bit at bit_idx this cycle
//   bit_idx  : slot to write
//   bit_in   : voted bit value
//   data     : assembled byte, [0] = first data bit on the line
// -----------------------------------------------------------------------------
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int WIDTH = DATA_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(WIDTH)-1:0] bit_idx,
  input  logic                     bit_in,
  output logic [0:WIDTH-1]         data
);

  // Per-slot write; slots not addressed keep their value. A reset mid-frame
  // throws away whatever partial byte had been collected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (wr_en) begin
      data[bit_idx] <= bit_in;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// uart_rx_deserializer
// UART receive path. Synchronises the serial line, finds the start bit,
// majority-votes three oversamples around the middle of every bit and
// rebuilds the byte, then checks parity and the stop bit.
// Frame: start(0), data[0..7], parity, stop(1).
// Ports:
//   baud_rate_rx : receive clock, OVERSAMPLE x baud rate
//   rst_n        : asynchronous active-low reset
//   s_data_in    : serial line, asynchronous, idle high
//   p_data_out   : last received byte, [0] = first data bit on the line
//   data_valid   : one-cycle strobe per completed frame
//   parity_error : parity mismatch on the last completed frame
//   stop_error   : stop bit sampled low on the last completed frame
//   busy         : receiver is inside a frame
// -----------------------------------------------------------------------------
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic       baud_rate_rx,
  input  logic       rst_n,
  input  logic       s_data_in,
  output logic [0:7] p_data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       stop_error,
  output logic       busy
);

  localparam int M     = OVERSAMPLE / 2;
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(M);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(M + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  // Expected XOR of data and parity bit for a clean frame.
  localparam logic PAR_SENSE = (PARITY_ODD != PARITY_EVEN);

  logic                 sync_ff1;
  logic                 rx_sync;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 armed;
  logic                 samp_a;
  logic                 samp_b;
  logic                 par_s;
  logic                 vote;
  logic                 sipo_wr;
  logic [0:DATA_BITS-1] shift_reg;

  // Two-flop synchroniser. Both stages reset high so the idle line does not
  // look like a start bit as reset is released.
  always_ff @(posedge baud_rate_rx or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff1 <= 1'b1;
      rx_sync  <= 1'b1;
    end else begin
      sync_ff1 <= s_data_in;
      rx_sync  <= sync_ff1;
    end
  end

  // The first two samples are stored; the third is the live rx_sync in the
  // decision cycle, so every decision below is taken at cnt == M+1.
  assign vote    = majority3(samp_a, samp_b, rx_sync);
  assign sipo_wr = (state == DATA) && (cnt == CNT_DEC);
  assign busy    = (state != IDLE);

  uart_rx_sipo #(
    .WIDTH (DATA_BITS)
  ) u_sipo (
    .clk     (baud_rate_rx),
    .rst_n   (rst_n),
    .wr_en   (sipo_wr),
    .bit_idx (bit_idx),
    .bit_in  (vote),
    .data    (shift_reg)
  );

  // Frame FSM with bit-period counter. The stop bit is resolved at its
  // mid-point rather than at the wrap, which returns to IDLE half a bit early
  // and leaves margin for a back-to-back start edge. armed blocks re-entry
  // after a framing error until the line has been seen high, so a held-low
  // break produces exactly one frame.
  always_ff @(posedge baud_rate_rx or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      armed        <= 1'b1;
      samp_a       <= 1'b0;
      samp_b       <= 1'b0;
      par_s        <= 1'b0;
      p_data_out   <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      if (state != IDLE) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        if (cnt == CNT_S0) samp_a <= rx_sync;
        if (cnt == CNT_S1) samp_b <= rx_sync;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_sync) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= START;
          end
        end

        START: begin
          if (cnt == CNT_DEC && vote) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            if (bit_idx == IDX_LAST) begin
              state   <= PARITY;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        PARITY: begin
          if (cnt == CNT_DEC) par_s <= vote;
          if (cnt == CNT_LAST) state <= STOP;
        end

        STOP: begin
          if (cnt == CNT_DEC) begin
            p_data_out   <= shift_reg;
            parity_error <= ((^shift_reg) ^ par_s) != PAR_SENSE;
            stop_error   <= ~vote;
            data_valid   <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
            if (!vote) armed <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deserializer
// Drives UART frames onto one serial line shared by an even-parity and an
// odd-parity receiver. Each frame pushes its expected result (byte, both
// parity verdicts, framing verdict, optional latency) into a queue; an
// independent monitor pops one entry per strobe and compares.
// -----------------------------------------------------------------------------
module tb_uart_rx_deserializer;

  localparam int OS      = 8;
  localparam int HALF    = 50;
  localparam int PERIOD  = 2 * HALF;
  localparam int BIT_NOM = OS * PERIOD;
  localparam int BIT_SLOW = (BIT_NOM * 103) / 100;
  localparam int BIT_FAST = (BIT_NOM * 97) / 100;
  localparam int LATENCY = 10 * OS + OS / 2 + 4;

  typedef struct {
    logic [0:7] data;
    logic       perrEven;
    logic       perrOdd;
    logic       serr;
    bit         checkLat;
    int         startEdge;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_data_in;
  logic [0:7] pdEven, pdOdd;
  logic       dvEven, dvOdd, peEven, peOdd, seEven, seOdd, busyEven, busyOdd;

  int checks = 0;
  int fails = 0;
  int cycleCount = 0;
  int busyCntE, busyCntO;
  frame_t expQ[$];

  logic [0:7] lastData = '0;
  logic       lastPeEven = 1'b0;
  logic       lastPeOdd = 1'b0;
  logic       lastSe = 1'b0;

  uart_rx_deserializer #(.OVERSAMPLE(OS), .PARITY_ODD(0)) dut (
    .baud_rate_rx (clk),
    .rst_n        (rst_n),
    .s_data_in    (s_data_in),
    .p_data_out   (pdEven),
    .data_valid   (dvEven),
    .parity_error (peEven),
    .stop_error   (seEven),
    .busy         (busyEven)
  );

  uart_rx_deserializer #(.OVERSAMPLE(OS), .PARITY_ODD(1)) dutOdd (
    .baud_rate_rx (clk),
    .rst_n        (rst_n),
    .s_data_in    (s_data_in),
    .p_data_out   (pdOdd),
    .data_valid   (dvOdd),
    .parity_error (peOdd),
    .stop_error   (seOdd),
    .busy         (busyOdd)
  );

  // Free-running clock and edge counter used for latency measurement.
  always #HALF clk = ~clk;
  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Places the next line transition just before a rising edge, so the
  // following edge is edge 0 of the frame.
  task automatic alignToClock();
    @(posedge clk);
    #(PERIOD - 5);
  endtask

  // Sends one frame and records what the receivers must report for it.
  task automatic applyStimulus(input logic [0:7] data, input logic par,
                               input logic stop, input int bitTime,
                               input int tailBits, input logic tailLevel,
                               input bit checkLat);
    frame_t e;
    e.data      = data;
    e.perrEven  = (^data) ^ par;
    e.perrOdd   = ~((^data) ^ par);
    e.serr      = ~stop;
    e.checkLat  = checkLat;
    e.startEdge = cycleCount + 1;
    expQ.push_back(e);
    s_data_in = 1'b0;
    #(bitTime);
    for (int i = 0; i < 8; i++) begin
      s_data_in = data[i];
      #(bitTime);
    end
    s_data_in = par;
    #(bitTime);
    s_data_in = stop;
    #(bitTime);
    if (tailBits > 0) begin
      s_data_in = tailLevel;
      #(bitTime * tailBits);
    end
    s_data_in = 1'b1;
  endtask

  task automatic countBusy(input int cycles);
    busyCntE = 0;
    busyCntO = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (busyEven) busyCntE++;
      if (busyOdd) busyCntO++;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_data_even"}, pdEven, 0);
    checkOutput({tag, "_data_odd"}, pdOdd, 0);
    checkOutput({tag, "_valid_even"}, dvEven, 0);
    checkOutput({tag, "_valid_odd"}, dvOdd, 0);
    checkOutput({tag, "_perr_even"}, peEven, 0);
    checkOutput({tag, "_perr_odd"}, peOdd, 0);
    checkOutput({tag, "_serr_even"}, seEven, 0);
    checkOutput({tag, "_serr_odd"}, seOdd, 0);
    checkOutput({tag, "_busy_even"}, busyEven, 0);
    checkOutput({tag, "_busy_odd"}, busyOdd, 0);
  endtask

  // Monitor: every strobe consumes one expected frame. A strobe with nothing
  // queued, or a strobe lasting two cycles, is reported as unexpected.
  always @(negedge clk) begin
    frame_t e;
    if (dvEven || dvOdd) begin
      if (expQ.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_strobe: data_valid even=%0b odd=%0b, expected 0",
                 dvEven, dvOdd);
      end else begin
        e = expQ.pop_front();
        checkOutput("strobe_even", dvEven, 1);
        checkOutput("strobe_odd", dvOdd, 1);
        checkOutput("byte_even", pdEven, e.data);
        checkOutput("byte_odd", pdOdd, e.data);
        checkOutput("perr_even", peEven, e.perrEven);
        checkOutput("perr_odd", peOdd, e.perrOdd);
        checkOutput("serr_even", seEven, e.serr);
        checkOutput("serr_odd", seOdd, e.serr);
        checkOutput("busy_at_strobe", busyEven, 0);
        if (e.checkLat) checkOutput("latency", cycleCount - e.startEdge, LATENCY);
        lastData   = e.data;
        lastPeEven = e.perrEven;
        lastPeOdd  = e.perrOdd;
        lastSe     = e.serr;
      end
    end
  end

  initial begin
    s_data_in = 1'b1;
    rst_n     = 1'b1;
    #10;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] clean frame and bad parity");
    alignToClock();
    applyStimulus(8'b10100101, 1'b0, 1'b1, BIT_NOM, 2, 1'b1, 1'b1);
    applyStimulus(8'b10100101, 1'b1, 1'b1, BIT_NOM, 2, 1'b1, 1'b1);

    $display("[TB] framing error followed by break");
    applyStimulus(8'b01101100, 1'b0, 1'b0, BIT_NOM, 30, 1'b0, 1'b1);
    #(2 * BIT_NOM);
    applyStimulus(8'b11100010, 1'b0, 1'b1, BIT_NOM, 2, 1'b1, 1'b1);

    $display("[TB] glitch in idle");
    alignToClock();
    s_data_in = 1'b0;
    #(2 * PERIOD);
    s_data_in = 1'b1;
    countBusy(3 * OS);
    checkOutput("glitch_busy_even", (busyCntE >= 1 && busyCntE <= OS), 1);
    checkOutput("glitch_busy_odd", (busyCntO >= 1 && busyCntO <= OS), 1);
    checkOutput("glitch_hold_data", pdEven, lastData);
    checkOutput("glitch_hold_perr_even", peEven, lastPeEven);
    checkOutput("glitch_hold_perr_odd", peOdd, lastPeOdd);
    checkOutput("glitch_hold_serr", seEven, lastSe);

    $display("[TB] back-to-back frames");
    alignToClock();
    applyStimulus(8'h3C, ^8'h3C, 1'b1, BIT_NOM, 0, 1'b1, 1'b1);
    applyStimulus(8'hC3, ^8'hC3, 1'b1, BIT_NOM, 2, 1'b1, 1'b1);

    $display("[TB] baud mismatch");
    alignToClock();
    applyStimulus(8'h3C, ^8'h3C, 1'b1, BIT_SLOW, 0, 1'b1, 1'b0);
    applyStimulus(8'hC3, ^8'hC3, 1'b1, BIT_SLOW, 2, 1'b1, 1'b0);
    // A faster source gets one idle bit between frames and a fresh alignment.
    alignToClock();
    applyStimulus(8'h3C, ^8'h3C, 1'b1, BIT_FAST, 1, 1'b1, 1'b0);
    alignToClock();
    applyStimulus(8'hC3, ^8'hC3, 1'b1, BIT_FAST, 2, 1'b1, 1'b0);

    $display("[TB] random frames");
    alignToClock();
    for (int f = 0; f < 20; f++) begin
      logic [0:7] d;
      logic       p;
      logic       s;
      int         tail;
      d    = 8'($urandom);
      p    = (^d) ^ ($urandom_range(0, 3) == 0);
      s    = ($urandom_range(0, 4) != 0);
      tail = s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      applyStimulus(d, p, s, BIT_NOM, tail, 1'b1, 1'b1);
    end

    for (int i = 0; i < 2000 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("[TB] reset mid-frame");
    alignToClock();
    s_data_in = 1'b0;
    repeat (30) @(posedge clk);
    #30;
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    s_data_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lastData   = '0;
    lastPeEven = 1'b0;
    lastPeOdd  = 1'b0;
    lastSe     = 1'b0;
    countBusy(3 * OS);
    checkOutput("post_reset_busy_even", busyCntE, 0);
    checkOutput("post_reset_busy_odd", busyCntO, 0);
    checkOutput("post_reset_data", pdEven, lastData);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

UART receive path: the counterpart of the transmit PISO shifter. It oversamples the serial line, detects the start bit, majority-votes each bit at mid-period, and reassembles the frame into a parallel byte. It checks parity and the stop bit and emits a one-cycle valid strobe per frame. The frame format matches the transmitter: start(0), data[0]..data[7] (index 0 first), parity, stop(1), for 11 bits per frame.

## Interface
- OVERSAMPLE, 8: clock cycles per bit; even, ≥ 4. M = OVERSAMPLE/2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity.

- baud_rate_rx  in  1  receive clock, OVERSAMPLE × baud rate
- rst_n  in  1  reset, asynchronous, active-low
- s_data_in  in  1  serial line, asynchronous to baud_rate_rx, idle high
- p_data_out  out  [0:7]  last received byte; [0] = first data bit on the line
- data_valid  out  1  one-cycle strobe, frame complete
- parity_error  out  1  parity mismatch on the last frame
- stop_error  out  1  stop bit sampled 0 on the last frame
- busy  out  1  high whenever state ≠ IDLE

One clock; reset is asynchronous and active-low (baud_rate_rx, rst_n).

## Operation
- Input path: 2-FF synchronizer feeding rx_sync. Both FFs reset to 1, so no false start comes out of reset.
- States and transitions:
  - IDLE: if armed and rx_sync == 0, go to START with cnt = 0.
  - START: bit 0 of the frame.
  - DATA: bits 1–8; bit_idx runs 0..7.
  - PARITY: bit 9.
  - STOP: bit 10.
- Bit-period counter:
  - cnt increments every cycle outside IDLE.
  - It wraps from OVERSAMPLE-1 to 0; the wrap advances the state or bit_idx.
- Sampling:
  - rx_sync is sampled at cnt = M-1, M and M+1.
  - The bit value is the majority of those three samples, decided in the cycle with cnt = M+1.
- START decision: if the vote is 1, the start is a glitch; return to IDLE with no flags and no strobe.
- DATA decision: shift_reg[bit_idx] <= vote. The wrap at bit_idx == 7 goes to PARITY.
- PARITY decision: latch par_s.
- STOP decision is taken at the decision cycle, not at the wrap. This gives half-bit margin for the next start bit. In the next cycle:
  - p_data_out <= shift_reg.
  - parity_error <= (^shift_reg ^ par_s) != PARITY_ODD.
  - stop_error <= ~vote.
  - data_valid <= 1 for exactly one cycle.
  - State goes to IDLE.
- Error reporting:
  - The byte is delivered even when flagged; the flags qualify it.
  - p_data_out and both flags hold until the next completed frame.
  - A false start never changes them.
- armed flag:
  - Cleared when stop_error is set.
  - Set again once rx_sync == 1 is seen in IDLE.
  - A held-low line (break) therefore yields exactly one frame, then waits for the line to go high.
- Reset at any time, including mid-frame:
  - State IDLE, cnt = 0, bit_idx = 0, armed = 1.
  - All outputs 0.
  - Partial frame discarded.

## Timing
- Reset values: p_data_out = 0, data_valid = 0, parity_error = 0, stop_error = 0, busy = 0.
- Latency: take edge 0 as the first edge that sees s_data_in low.
  - START is entered after edge 2.
  - data_valid is high in the cycle after edge 10·OVERSAMPLE + M + 4, which is edge 88 at the defaults.
- busy: rises after edge 2 and falls in the same cycle data_valid rises.
- Back-to-back frames: IDLE is re-entered M+2 cycles into the stop bit. A start edge at the nominal end of the stop bit is therefore detected. Strobes come 11·OVERSAMPLE cycles apart for a jitter-free source.
- Tolerance: the glitch filter rejects any low pulse shorter than M-1 cycles that is followed by high at the start-bit sample points.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS = 8 and FRAME_BITS = 11;
  - PARITY_EVEN / PARITY_ODD constants, shared with the transmit side.
- One sub-module, uart_rx_sipo: serial-in/parallel-out register with per-index write enable, indexed by bit_idx and cleared by rst_n. The FSM, counter, synchronizer and voter stay in the top module.

## Test plan
- **Reset:** assert rst_n = 0 mid-frame.
  - All outputs go to 0 immediately.
  - After release with the line high, busy stays 0 and no strobe appears.
- **Clean frame:** data bits 1,0,1,0,0,1,0,1, parity 0, stop 1, at OVERSAMPLE = 8.
  - p_data_out[0:7] = 8'b10100101.
  - data_valid is a single pulse after edge 88.
  - parity_error = 0, stop_error = 0.
- **Bad parity:** same frame with parity = 1.
  - p_data_out = 8'b10100101, parity_error = 1, stop_error = 0.
  - With PARITY_ODD = 1, the same frame gives parity_error = 0.
- **Framing and break:** stop bit = 0, then the line is held low for 30 more bit times.
  - One strobe with stop_error = 1.
  - No further strobes until the line goes high; the next good frame clears stop_error.
- **Glitch:** a 2-cycle low pulse in idle.
  - busy pulses for at most one bit period; no data_valid; outputs unchanged.
- **Back-to-back:** frames 0x3C then 0xC3 with no idle gap.
  - Two strobes exactly 88 cycles apart, both bytes correct.
  - Repeat with ±3% baud mismatch: still correct.
